// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM states and instruction field positions.
package fetch_pkg;

    localparam int unsigned InstrWidth  = 32;
    localparam int unsigned PcIncr      = 4;
    localparam int unsigned OpcodeMsb   = 31;
    localparam int unsigned OpcodeLsb   = 26;
    localparam int unsigned FuncMsb     = 5;
    localparam int unsigned FuncLsb     = 0;
    localparam int unsigned OpcodeWidth = OpcodeMsb - OpcodeLsb + 1;
    localparam int unsigned FuncWidth   = FuncMsb - FuncLsb + 1;

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StBlocked
    } fetch_state_e;

    function automatic logic [OpcodeWidth-1:0] get_opcode(input logic [InstrWidth-1:0] instr);
        return instr[OpcodeMsb:OpcodeLsb];
    endfunction

    function automatic logic [FuncWidth-1:0] get_func(input logic [InstrWidth-1:0] instr);
        return instr[FuncMsb:FuncLsb];
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word and its PC+4 while the decoder stalls.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int unsigned Aw = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [InstrWidth-1:0] data_i,
    input  logic [Aw-1:0]         pc4_i,
    output logic [InstrWidth-1:0] data_o,
    output logic [Aw-1:0]         pc4_o,
    output logic                  full_o
);

    logic [InstrWidth-1:0] data_q;
    logic [Aw-1:0]         pc4_q;
    logic                  full_q;

    // Flush wins over push so a redirect can never leave a stale word behind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            pc4_q  <= '0;
            full_q <= 1'b0;
        end else if (flush_i) begin
            full_q <= 1'b0;
        end else if (push_i) begin
            data_q <= data_i;
            pc4_q  <= pc4_i;
            full_q <= 1'b1;
        end else if (pop_i) begin
            full_q <= 1'b0;
        end
    end

    assign data_o = data_q;
    assign pc4_o  = pc4_q;
    assign full_o = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and feeds the decoder.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned   Aw      = 32,
    parameter logic [Aw-1:0] ResetPc = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   imem_req_o,
    output logic [Aw-1:0]          imem_addr_o,
    input  logic                   imem_ready_i,
    input  logic [InstrWidth-1:0]  imem_rdata_i,
    input  logic                   stall_i,
    input  logic                   pcsrc_i,
    input  logic [Aw-1:0]          branch_target_i,
    output logic [InstrWidth-1:0]  instr_o,
    output logic                   instr_valid_o,
    output logic [Aw-1:0]          pc_plus4_o,
    output logic [OpcodeWidth-1:0] opcode_o,
    output logic [FuncWidth-1:0]   func_o
);

    localparam logic [Aw-1:0] Incr = Aw'(PcIncr);

    fetch_state_e          state_q, state_d;
    logic [Aw-1:0]         pc_q, pc_d;
    logic [Aw-1:0]         tgt_q, tgt_d;
    logic                  discard_q, discard_d;
    logic [InstrWidth-1:0] instr_q, instr_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [Aw-1:0]         pc_plus4_q, pc_plus4_d;

    logic                  skid_push, skid_pop, skid_flush, skid_full;
    logic [InstrWidth-1:0] skid_data;
    logic [Aw-1:0]         skid_pc4;
    logic [Aw-1:0]         pc_inc;
    logic                  consume;

    assign pc_inc  = pc_q + Incr;
    assign consume = instr_valid_q && !stall_i;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        tgt_d         = tgt_q;
        discard_d     = discard_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pc_plus4_d    = pc_plus4_q;
        skid_push     = 1'b0;
        skid_pop      = 1'b0;
        skid_flush    = 1'b0;

        if (pcsrc_i) begin
            instr_valid_d = 1'b0;
            skid_flush    = 1'b1;
            state_d       = StFetch;
            // An in-flight request must complete on its old address; remember the target.
            if (state_q == StFetch && !imem_ready_i) begin
                discard_d = 1'b1;
                tgt_d     = branch_target_i;
            end else begin
                discard_d = 1'b0;
                pc_d      = branch_target_i;
            end
        end else begin
            if (consume) begin
                instr_valid_d = 1'b0;
            end
            unique case (state_q)
                StBoot: state_d = StFetch;
                StFetch: begin
                    if (imem_ready_i) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            pc_d      = tgt_q;
                        end else begin
                            pc_d = pc_inc;
                            if (!instr_valid_q || consume) begin
                                instr_d       = imem_rdata_i;
                                pc_plus4_d    = pc_inc;
                                instr_valid_d = 1'b1;
                            end else begin
                                skid_push = 1'b1;
                                state_d   = StBlocked;
                            end
                        end
                    end
                end
                StBlocked: begin
                    if (consume) begin
                        instr_d       = skid_data;
                        pc_plus4_d    = skid_pc4;
                        instr_valid_d = 1'b1;
                        skid_pop      = 1'b1;
                        state_d       = StFetch;
                    end
                end
                default: state_d = StBoot;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StBoot;
            pc_q          <= ResetPc;
            tgt_q         <= '0;
            discard_q     <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_plus4_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tgt_q         <= tgt_d;
            discard_q     <= discard_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_plus4_q    <= pc_plus4_d;
        end
    end

    fetch_skid_buf #(
        .Aw(Aw)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (skid_push),
        .pop_i  (skid_pop),
        .flush_i(skid_flush),
        .data_i (imem_rdata_i),
        .pc4_i  (pc_inc),
        .data_o (skid_data),
        .pc4_o  (skid_pc4),
        .full_o (skid_full)
    );

    assign imem_req_o    = (state_q == StFetch);
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign pc_plus4_o    = pc_plus4_q;
    assign opcode_o      = get_opcode(instr_q);
    assign func_o        = get_func(instr_q);

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the matrix instruction decoder/controller.
- Owns the PC and drives a request/ready handshake to instruction memory.
- Presents a registered instruction word, with opcode and func fields split out, to the decoder.
- Absorbs decode stalls with a one-entry skid buffer and accepts PC redirects (branch taken, the PCSrc path) from downstream.

Parameters:
- AW, 32, PC/address width (bits).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- ImemReq  out  1  fetch request; once asserted, held until ImemReady.
- ImemAddr  out  AW  fetch address (= PC); stable while ImemReq=1.
- ImemReady  in  1  response strobe; ImemRdata valid in the same cycle.
- ImemRdata  in  32  instruction word.
- Stall  in  1  decoder cannot consume Instr this cycle.
- PCSrc  in  1  one-cycle redirect pulse (branch taken).
- BranchTarget  in  AW  redirect address, sampled when PCSrc=1.
- Instr  out  32  registered instruction presented to the decoder.
- InstrValid  out  1  Instr holds a live instruction.
- PCPlus4  out  AW  address of Instr + 4.
- opcode  out  6  Instr[31:26], combinational from Instr.
- func  out  6  Instr[5:0], combinational from Instr.

Behaviour:
- Reset values (async, Rst_n=0):
  - PC=RESET_PC, ImemReq=0, Instr=0, InstrValid=0, PCPlus4=0.
  - Skid buffer empty; Discard=0; state=BOOT.
- State machine: BOOT, FETCH, BLOCKED.
  - BOOT: lasts one cycle after Rst_n deasserts, then goes to FETCH with ImemReq=1.
  - FETCH: ImemReq=1, ImemAddr=PC.
  - BLOCKED: ImemReq=0; entered when a response lands in the skid buffer.
- Consume: when InstrValid=1 and Stall=0, Instr is consumed at that edge.
- Response handling (ImemReady=1 in FETCH, Discard=0):
  - PC <= PC+4.
  - If Instr is free (InstrValid=0, or being consumed), load Instr <= ImemRdata, PCPlus4 <= PC+4, InstrValid <= 1, and stay in FETCH with the next request issued the following cycle.
  - Otherwise write the word and PC+4 into the skid buffer and go to BLOCKED.
- Latency: a response lands on Instr one edge after ImemReady; there is no bubble between back-to-back zero-wait responses when Stall=0.
- BLOCKED: on the first cycle Instr is consumed, move skid -> Instr (InstrValid stays 1), empty the skid, and go to FETCH.
- InstrValid clears on consume unless a new word loads in the same edge.
- Redirect (PCSrc=1) has priority over Stall and over responses:
  - Flush Instr: InstrValid <= 0 (Instr contents are don't-care).
  - Empty the skid buffer.
  - PC <= BranchTarget.
  - If a request is outstanding and ImemReady=0 this cycle, set Discard=1. ImemReq stays high on the old address until ImemReady, that response is dropped, then Discard clears and the next request goes to the new PC.
  - If ImemReady=1 in the same cycle as PCSrc, drop the response and request BranchTarget next cycle.
  - A redirect from BLOCKED goes to FETCH.
  - A second redirect while Discard=1 overwrites PC; only the latest target is fetched.
- Arithmetic: PC+4 is modulo 2^AW and wraps silently (32'hFFFF_FFFC -> 0).
- Reset mid-transaction: ImemReq drops immediately (async); any memory response arriving during reset is ignored.
- Assertions (bench):
  - ImemAddr is stable while ImemReq=1 and ImemReady=0.
  - The skid buffer is never written while full.
  - InstrValid=0 in the cycle after PCSrc.

Decomposition:
- Shared package: fetch state enum (BOOT/FETCH/BLOCKED), opcode/func field bit positions, PC_INCR=4, instruction width 32. The decoder uses the same field constants.
- One sub-module: fetch_skid_buf, a one-entry buffer {data, pc4, full} with push/pop/flush inputs, sharing Clk/Rst_n.

Test Plan:
- Reset release, memory always ready, Stall=0 -> first ImemAddr=0; Instr=mem[0],mem[4],mem[8] on consecutive cycles; PCPlus4=4,8,12.
- Memory with a 3-cycle ready delay -> ImemAddr held at 0x4 for 3 cycles; InstrValid=1 for exactly one cycle per instruction.
- Stall held 4 cycles while a response arrives -> skid fills, ImemReq=0 (BLOCKED); on release the skid word appears with no loss or duplication and the order is preserved.
- PCSrc=1, BranchTarget=0x40, while a request to 0x10 is outstanding -> 0x10 response dropped, next ImemAddr=0x40, and the first valid Instr is mem[0x40].
- PCSrc coincident with ImemReady and Stall=1 with a full skid -> skid and Instr flushed; next fetch address = target.
- RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0; Rst_n asserted mid-wait -> ImemReq=0 and InstrValid=0 immediately.
